// File: rtl/mem_access_unit.sv
// Memory access stage: one handshaked access per command level, owns IR/MDR; optional MEM_TIMEOUT_EN no-ack guard.
// Latency: done 2 cycles after command with zero-wait memory, +1 per wait cycle; backpressure: busy holds controller.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, tgt_q, tgt_d, done_q, done_d;
  logic              tmo_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter is reset on ACCESS entry and fires on the last allowed ACCESS cycle.
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_hit = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !mem_ack) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit = 1'b1;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          // Read wins when both commands are raised together.
          we_d    = mem_write & ~mem_read;
          addr_d  = i_or_d ? alu_out_in : pc_in;
          wdata_d = wdata_in;
          tgt_d   = i_or_d;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            if (tgt_q) mdr_d = mem_rdata;
            else       ir_d  = mem_rdata;
          end
          done_d  = 1'b1;
          state_d = HOLD;
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Wait for the command level to drop so a held level gives one access.
        if (!(mem_read || mem_write)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      tgt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign mem_req   = (state_q == ACCESS);
  assign busy      = (state_q == ACCESS);
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ir_out    = ir_q;
  assign mdr_out   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store, held commands, reset abort, no-ack behaviour.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, i_or_d, mem_ack;
  logic [31:0] pc_in, alu_out_in, wdata_in, mem_rdata;
  logic [31:0] ir_out, mdr_out, mem_addr, mem_wdata;
  logic        busy, done, mem_req, mem_we, timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_a, cnt_b;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .pc_in(pc_in), .alu_out_in(alu_out_in), .wdata_in(wdata_in),
    .ir_out(ir_out), .mdr_out(mdr_out), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_read = 0; mem_write = 0; i_or_d = 0; mem_ack = 0;
    pc_in = 0; alu_out_in = 0; wdata_in = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_mdr", mdr_out, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch, zero-wait memory.
    pc_in = 32'h10; i_or_d = 0; mem_read = 1;
    @(negedge clk);
    chk("f_req", mem_req, 1);
    chk("f_busy", busy, 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", mem_we, 0);
    chk("f_done_early", done, 0);
    mem_ack = 1; mem_rdata = 32'h4C000005; mem_read = 0;
    @(negedge clk);
    mem_ack = 0;
    chk("f_done", done, 1);
    chk("f_req_off", mem_req, 0);
    chk("f_ir", ir_out, 32'h4C000005);
    chk("f_mdr", mdr_out, 0);
    @(negedge clk);
    chk("f_done_pulse", done, 0);

    // Ack in IDLE must be ignored.
    mem_ack = 1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    mem_ack = 0;
    chk("idle_ack_ir", ir_out, 32'h4C000005);
    chk("idle_ack_busy", busy, 0);

    // Load with three wait cycles.
    alu_out_in = 32'h20; i_or_d = 1; mem_read = 1;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_read = 0;
      cnt_a += int'(busy);
      if (i == 0) chk("l_addr", mem_addr, 32'h20);
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
    end
    @(negedge clk);
    mem_ack = 0;
    chk("l_busy_cycles", cnt_a, 4);
    chk("l_done", done, 1);
    chk("l_mdr", mdr_out, 32'hDEADBEEF);
    chk("l_ir", ir_out, 32'h4C000005);
    @(negedge clk);

    // Store with inputs changing mid-access.
    alu_out_in = 32'h30; i_or_d = 1; wdata_in = 32'h12345678; mem_write = 1;
    @(negedge clk);
    wdata_in = 32'hFFFF0000; alu_out_in = 32'h99; mem_write = 0;
    chk("s_we", mem_we, 1);
    chk("s_addr", mem_addr, 32'h30);
    chk("s_wdata", mem_wdata, 32'h12345678);
    @(negedge clk);
    chk("s_wdata_held", mem_wdata, 32'h12345678);
    chk("s_addr_held", mem_addr, 32'h30);
    mem_ack = 1; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    mem_ack = 0;
    chk("s_done", done, 1);
    chk("s_ir", ir_out, 32'h4C000005);
    chk("s_mdr", mdr_out, 32'hDEADBEEF);
    @(negedge clk);

    // Held read gives one access; ack during HOLD ignored.
    pc_in = 32'h40; i_or_d = 0; mem_read = 1;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("h_done", done, 1);
    mem_rdata = 32'h22222222;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt_a += int'(mem_req);
      cnt_b += int'(done);
    end
    mem_ack = 0;
    chk("h_no_req", cnt_a, 0);
    chk("h_no_done", cnt_b, 0);
    chk("h_ir", ir_out, 32'h11111111);
    mem_read = 0;
    @(negedge clk);
    chk("h_idle", busy, 0);
    pc_in = 32'h44; mem_read = 1; mem_write = 1; wdata_in = 32'h5A5A5A5A;
    @(negedge clk);
    chk("h2_req", mem_req, 1);
    chk("h2_we", mem_we, 0);
    chk("h2_addr", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h33333333; mem_read = 0; mem_write = 0;
    @(negedge clk);
    mem_ack = 0;
    chk("h2_done", done, 1);
    chk("h2_ir", ir_out, 32'h33333333);
    @(negedge clk);

    // Asynchronous reset in the middle of an access.
    alu_out_in = 32'h50; i_or_d = 1; mem_read = 1;
    @(negedge clk);
    mem_read = 0;
    chk("r_req_before", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("r_req", mem_req, 0);
    chk("r_busy", busy, 0);
    chk("r_addr", mem_addr, 0);
    chk("r_ir", ir_out, 0);
    chk("r_mdr", mdr_out, 0);
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ack = 0;
    chk("r_idle", busy, 0);
    chk("r_mdr_after", mdr_out, 0);

    // No acknowledge.
    pc_in = 32'h60; i_or_d = 0; mem_read = 1;
`ifdef MEM_TIMEOUT_EN
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_read = 0;
      cnt_a += int'(mem_req);
      cnt_b += int'(done);
    end
    chk("t_req_cycles", cnt_a, 4);
    chk("t_done_pulses", cnt_b, 1);
    chk("t_err", timeout_err, 1);
    chk("t_ir", ir_out, 0);
    pc_in = 32'h64; mem_read = 1;
    @(negedge clk);
    mem_read = 0; mem_ack = 1; mem_rdata = 32'h99;
    @(negedge clk);
    mem_ack = 0;
    chk("t_err_sticky", timeout_err, 1);
    chk("t_ir_after", ir_out, 32'h99);
`else
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mem_read = 0;
      cnt_a += int'(mem_req);
    end
    chk("t_req_cycles", cnt_a, 100);
    chk("t_err", timeout_err, 0);
    mem_ack = 1; mem_rdata = 32'h99;
    @(negedge clk);
    mem_ack = 0;
    chk("t_done", done, 1);
    chk("t_ir", ir_out, 32'h99);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
